noc_inject_arbiter: RTL and testbench
=====================================

# noc_inject_arbiter

Packet-granular round-robin arbiter that shares one NoC router local injection port among `NUM_REQ` local requesters (PEs, DMA engines, test nodes). It sits between the requesters and a node's `receive_*` flit port on the NoC connector. It locks the grant from a header flit through its tail flit, so wormhole packets are never interleaved. A one-entry registered output slot gives full-throughput streaming with one cycle of latency.

## Interface
- `NUM_REQ`, 4: number of requesters; ≥2.
- `DATA_WIDTH`, `` `Noc_Data_Width ``: flit width in bits.
- `IDW`, `$clog2(NUM_REQ)`: grant index width.

Ports:
- `noc_clk` in 1: clock.
- `noc_rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester flit valid.
- `req_ready` out NUM_REQ: per-requester flit accepted this cycle (when valid is also high).
- `req_flit` in NUM_REQ*DATA_WIDTH: flits; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_is_header` in NUM_REQ: first flit of a packet.
- `req_is_tail` in NUM_REQ: last flit of a packet. Header and tail both high means a single-flit packet.
- `noc_valid` out 1: output flit valid, drives the router `receive_valid`.
- `noc_ready` in 1: router `receive_ready`.
- `noc_flit` out DATA_WIDTH: output flit.
- `noc_is_header` out 1: header marker of the output flit.
- `noc_is_tail` out 1: tail marker of the output flit.
- `grant_id` out IDW: current or last owner.
- `busy` out 1: packet lock held.
- `err_orphan` out 1: sticky error flag. Set when a non-header flit is presented by a non-owner while the arbiter is IDLE.

## Operation
- **State machine:** two states, IDLE and LOCK. The owner is held in register `owner`. The round-robin pointer `ptr` (IDW bits) is the highest-priority index.
- **Slot:** `slot_free = !noc_valid || noc_ready`.
- **IDLE winner:** candidates are requesters with `req_valid & req_is_header`. The winner is the first candidate at or after `ptr`, searching cyclically with wrap at NUM_REQ-1 → 0.
- **IDLE ready:** `req_ready[winner] = slot_free`. All other ready bits are 0.
- **IDLE acceptance:**
  - Accepted header without tail → LOCK, `owner <= winner`.
  - Accepted header with tail (single-flit packet) → stay IDLE, `ptr <= winner+1` (mod NUM_REQ).
- **LOCK ready:** `req_ready[owner] = slot_free`. All other ready bits are 0, even if other requesters have valid headers.
- **LOCK acceptance:** an accepted tail → IDLE, `ptr <= owner+1` (mod NUM_REQ).
- **Owner stalls:** if the owner drops `req_valid` mid-packet, the lock is held indefinitely. No other requester is served (wormhole semantics).
- **Flit transfer:** an accepted flit is written into the output slot on the next edge: `noc_valid <= 1`, and flit/header/tail copied. If `noc_ready` is high and no flit is accepted, `noc_valid <= 0`.
- **grant_id / busy:** `grant_id` updates to the winner on every accepted header. `busy = (state == LOCK)`, registered.
- **err_orphan:** set when, in IDLE, any `req_valid[i] & !req_is_header[i]` is present. It clears only on reset.
- **Not checked:** header flags appearing mid-packet from the owner are passed through unchecked.
- **Requester rule:** flit and flags must stay stable while `valid & !ready`. The arbiter relies on this and does not check it.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `owner`=0, `noc_valid`=0, `noc_flit`=0, `noc_is_header`=0, `noc_is_tail`=0, `grant_id`=0, `busy`=0, `err_orphan`=0. `req_ready` is 0 during reset.
- **Latency:** an input flit accepted at edge N appears on `noc_*` after edge N+1 and holds until `noc_valid & noc_ready`.
- **Throughput:** 1 flit per cycle within a packet while `noc_ready` stays high.
- **Packet gap:** one input-side idle cycle between a tail and the next header. Arbitration restarts in IDLE, so this applies to single-flit packets too.
- **Backpressure:** `noc_ready` low with `noc_valid` high forces `slot_free`=0. All `req_ready` are 0 and the output is held stable.
- **Simultaneous events:** tail acceptance and a new header in the same cycle → the header is not accepted that cycle.
- **Reset mid-packet:** the lock, the slot contents and `ptr` are discarded. Any partial packet already forwarded is not completed.

## Test plan
- **Single packet:** requester 2 sends a 4-flit packet (H, D, D, T: 0xA0–0xA3) with `noc_ready`=1 → 4 consecutive `noc_valid` cycles starting 1 cycle after the first accept. `grant_id`=2, `busy` high for the header through the tail, then `ptr`=3.
- **Contention:** all 4 requesters present 2-flit packets at the same time after reset → packets delivered in order 0, 1, 2, 3, never interleaved, with 1 bubble between packets. `ptr` returns to 0.
- **Backpressure:** `noc_ready` held low for 5 cycles mid-packet → `noc_flit` is held constant and `req_ready` is all 0. Streaming resumes without flit loss or duplication.
- **Lock hold:** the owner (req 1) drops valid for 3 cycles mid-packet while req 3 presents a header → req 3 is not served until req 1's tail is accepted.
- **Single-flit packets:** req 0 and req 1 each send H+T packets back-to-back → alternating grants. `busy` stays 0 and `err_orphan` stays 0.
- **Orphan and reset:**
  - Req 2 presents a non-header flit in IDLE → `err_orphan`=1 on the next cycle and the flit is not accepted.
  - Asserting `noc_rst` mid-packet → all outputs are at reset values the following cycle and `err_orphan`=0.

Source files
------------

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter feeding one NoC local injection port.
// The grant is locked from header to tail; accepted flits land in a one-entry output slot.

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = `Noc_Data_Width,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]            req_is_header,
    input  logic [NUM_REQ-1:0]            req_is_tail,
    output logic                          noc_valid,
    input  logic                          noc_ready,
    output logic [DATA_WIDTH-1:0]         noc_flit,
    output logic                          noc_is_header,
    output logic                          noc_is_tail,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    output logic                          err_orphan
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                  state_reg;
    logic [IDW-1:0]          ptr_reg;
    logic [IDW-1:0]          owner_reg;
    logic                    gap_reg;
    logic                    noc_valid_reg;
    logic [DATA_WIDTH-1:0]   noc_flit_reg;
    logic                    noc_is_header_reg;
    logic                    noc_is_tail_reg;
    logic [IDW-1:0]          grant_reg;
    logic                    err_reg;

    logic [NUM_REQ-1:0]      cand;
    logic [NUM_REQ-1:0]      orphan;
    logic [DATA_WIDTH-1:0]   flit_arr [NUM_REQ];
    logic                    win_found;
    logic [IDW-1:0]          winner;
    logic [IDW-1:0]          sel;
    logic [IDW-1:0]          ptr_inc;
    logic                    slot_free;
    logic                    grant_en;
    logic                    accept;
    logic                    tail_sel;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign cand[gi]     = req_valid[gi] & req_is_header[gi];
            assign orphan[gi]   = req_valid[gi] & ~req_is_header[gi];
            assign flit_arr[gi] = req_flit[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Descending scan so the last hit is the candidate closest to ptr_reg.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand[(int'(ptr_reg) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                winner    = IDW'((int'(ptr_reg) + k) % NUM_REQ);
            end
        end
    end

    assign slot_free = !noc_valid_reg || noc_ready;
    assign sel       = (state_reg == LOCK) ? owner_reg : winner;
    // gap_reg enforces the idle input cycle that follows every tail.
    assign grant_en  = !noc_rst && ((state_reg == LOCK) || (win_found && !gap_reg));
    assign req_ready = (grant_en && slot_free) ? (NUM_REQ'(1) << sel) : '0;
    assign accept    = |(req_ready & req_valid);
    assign tail_sel  = req_is_tail[sel];
    assign ptr_inc   = (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + IDW'(1);

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_reg         <= IDLE;
            ptr_reg           <= '0;
            owner_reg         <= '0;
            gap_reg           <= 1'b0;
            noc_valid_reg     <= 1'b0;
            noc_flit_reg      <= '0;
            noc_is_header_reg <= 1'b0;
            noc_is_tail_reg   <= 1'b0;
            grant_reg         <= '0;
            err_reg           <= 1'b0;
        end else begin
            gap_reg <= accept && tail_sel;

            if (accept) begin
                noc_valid_reg     <= 1'b1;
                noc_flit_reg      <= flit_arr[sel];
                noc_is_header_reg <= req_is_header[sel];
                noc_is_tail_reg   <= tail_sel;
            end else if (noc_ready) begin
                noc_valid_reg <= 1'b0;
            end

            if (state_reg == IDLE && |orphan) begin
                err_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        grant_reg <= winner;
                        if (tail_sel) begin
                            ptr_reg <= ptr_inc;
                        end else begin
                            state_reg <= LOCK;
                            owner_reg <= winner;
                        end
                    end
                end
                LOCK: begin
                    if (accept && tail_sel) begin
                        state_reg <= IDLE;
                        ptr_reg   <= ptr_inc;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign noc_valid     = noc_valid_reg;
    assign noc_flit      = noc_flit_reg;
    assign noc_is_header = noc_is_header_reg;
    assign noc_is_tail   = noc_is_tail_reg;
    assign grant_id      = grant_reg;
    assign busy          = (state_reg == LOCK);
    assign err_orphan    = err_reg;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.

module tb_noc_inject_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 16;
    localparam int IW  = 2;

    logic              noc_clk;
    logic              noc_rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_flit;
    logic [NR-1:0]     req_is_header;
    logic [NR-1:0]     req_is_tail;
    logic              noc_valid;
    logic              noc_ready;
    logic [DW-1:0]     noc_flit;
    logic              noc_is_header;
    logic              noc_is_tail;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              err_orphan;

    noc_inject_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDW(IW)) dut (
        .noc_clk       (noc_clk),
        .noc_rst       (noc_rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_flit      (req_flit),
        .req_is_header (req_is_header),
        .req_is_tail   (req_is_tail),
        .noc_valid     (noc_valid),
        .noc_ready     (noc_ready),
        .noc_flit      (noc_flit),
        .noc_is_header (noc_is_header),
        .noc_is_tail   (noc_is_tail),
        .grant_id      (grant_id),
        .busy          (busy),
        .err_orphan    (err_orphan)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_owner = -1, nx_owner = -1;
    int            m_ptr = 0, nx_ptr = 0;
    int            m_grant = 0, nx_grant = 0;
    bit            m_gap = 0, nx_gap = 0;
    bit            m_ov = 0, nx_ov = 0;
    logic [DW-1:0] m_of = '0, nx_of = '0;
    bit            m_oh = 0, nx_oh = 0;
    bit            m_ot = 0, nx_ot = 0;
    bit            m_err = 0, nx_err = 0;
    bit            m_started = 0, nx_started = 0;

    always @(negedge noc_clk) begin : model_chk
        logic [NR-1:0] er;
        int a;
        int i;
        bit sf;
        er = '0;
        a  = -1;
        if (m_started) begin
            check_eq("noc_valid", noc_valid, m_ov);
            if (m_ov) begin
                check_eq("noc_flit", noc_flit, m_of);
                check_eq("noc_is_header", noc_is_header, m_oh);
                check_eq("noc_is_tail", noc_is_tail, m_ot);
            end
            check_eq("busy", busy, (m_owner >= 0));
            check_eq("grant_id", grant_id, m_grant);
            check_eq("err_orphan", err_orphan, m_err);
        end
        sf = !m_ov || noc_ready;
        if (!noc_rst) begin
            if (m_owner >= 0) begin
                er[m_owner] = sf;
            end else if (!m_gap) begin
                for (int k = 0; k < NR; k++) begin
                    i = (m_ptr + k) % NR;
                    if (req_valid[i] && req_is_header[i]) begin
                        er[i] = sf;
                        break;
                    end
                end
            end
        end
        if (m_started || noc_rst) check_eq("req_ready", req_ready, er);

        nx_owner = m_owner; nx_ptr = m_ptr; nx_grant = m_grant; nx_gap = 0;
        nx_ov = m_ov; nx_of = m_of; nx_oh = m_oh; nx_ot = m_ot;
        nx_err = m_err; nx_started = m_started;
        if (noc_rst) begin
            nx_owner = -1; nx_ptr = 0; nx_grant = 0; nx_ov = 0;
            nx_of = '0; nx_oh = 0; nx_ot = 0; nx_err = 0; nx_started = 1;
        end else if (m_started) begin
            for (int k = 0; k < NR; k++) if (er[k] && req_valid[k]) a = k;
            if (m_owner < 0 && |(req_valid & ~req_is_header)) nx_err = 1;
            if (a >= 0) begin
                nx_ov = 1;
                nx_of = req_flit[a*DW +: DW];
                nx_oh = req_is_header[a];
                nx_ot = req_is_tail[a];
                if (m_owner < 0) begin
                    nx_grant = a;
                    if (!req_is_tail[a]) nx_owner = a;
                end
                if (req_is_tail[a]) begin
                    nx_owner = -1;
                    nx_ptr   = (a + 1) % NR;
                    nx_gap   = 1;
                end
            end else if (noc_ready) begin
                nx_ov = 0;
            end
        end
    end

    always @(posedge noc_clk) begin
        m_owner <= nx_owner; m_ptr <= nx_ptr; m_grant <= nx_grant; m_gap <= nx_gap;
        m_ov <= nx_ov; m_of <= nx_of; m_oh <= nx_oh; m_ot <= nx_ot;
        m_err <= nx_err; m_started <= nx_started;
    end

    // ---------------- stimulus driver and output monitor ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic          h;
        logic          t;
    } flit_t;

    flit_t         txq [NR][$];
    logic [NR-1:0] en = '1;
    bit            rnd_valid = 0;
    bit            rnd_ready = 0;
    bit            rdy_val = 1;
    bit            busy_seen = 0;
    logic [DW-1:0] out_q[$];
    int            out_cyc[$];
    int            cyc = 0;

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (txq[i].size() > 0 && en[i] && (!rnd_valid || $urandom_range(3) != 0)) begin
                req_valid[i]          = 1'b1;
                req_flit[i*DW +: DW]  = txq[i][0].d;
                req_is_header[i]      = txq[i][0].h;
                req_is_tail[i]        = txq[i][0].t;
            end else begin
                req_valid[i]          = 1'b0;
                req_flit[i*DW +: DW]  = '0;
                req_is_header[i]      = 1'b0;
                req_is_tail[i]        = 1'b0;
            end
        end
        noc_ready = rnd_ready ? ($urandom_range(3) != 0) : rdy_val;
    endtask

    initial begin : driver
        logic [NR-1:0] acc_seen;
        req_valid = '0; req_flit = '0; req_is_header = '0; req_is_tail = '0;
        noc_ready = 1'b1;
        noc_rst   = 1'b1;
        forever begin
            @(negedge noc_clk);
            acc_seen = req_valid & req_ready;
            if (noc_valid && noc_ready) begin
                out_q.push_back(noc_flit);
                out_cyc.push_back(cyc);
            end
            if (busy) busy_seen = 1;
            @(posedge noc_clk);
            #1;
            cyc++;
            for (int i = 0; i < NR; i++)
                if (acc_seen[i] && txq[i].size() > 0) void'(txq[i].pop_front());
            drive_inputs();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge noc_clk);
        #2;
    endtask

    task automatic clear_out();
        out_q.delete();
        out_cyc.delete();
    endtask

    task automatic clear_txq();
        for (int i = 0; i < NR; i++) txq[i].delete();
    endtask

    task automatic do_reset();
        noc_rst = 1'b1;
        clear_txq();
        en = '1;
        drive_inputs();
        tick(2);
        noc_rst = 1'b0;
        drive_inputs();
        clear_out();
    endtask

    task automatic push_pkt(input int id, input int len, input int base);
        for (int j = 0; j < len; j++)
            txq[id].push_back('{d: DW'(base + j), h: (j == 0), t: (j == len - 1)});
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (out_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        check_eq(tag, (out_q.size() >= n), 1);
    endtask

    task automatic wait_sent(input string tag, input int id, input int left, input int budget);
        int c;
        c = 0;
        while (txq[id].size() > left && c < budget) begin
            tick(1);
            c++;
        end
        check_eq(tag, (txq[id].size() <= left), 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int total;
        int len;
        logic [DW-1:0] held;
        logic [DW-1:0] exp5 [6];
        tick(3);
        noc_rst = 1'b0;
        drive_inputs();
        tick(1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_noc_valid", noc_valid, 0);

        // Single 4-flit packet from requester 2
        do_reset();
        push_pkt(2, 4, 'hA0);
        drive_inputs();
        wait_out("t1_wait", 4, 50);
        for (int j = 0; j < 4; j++) check_eq("t1_flit", out_q[j], DW'('hA0 + j));
        check_eq("t1_back_to_back", out_cyc[3] - out_cyc[0], 3);
        check_eq("t1_grant", grant_id, 2);
        check_eq("t1_busy_after", busy, 0);
        clear_out();
        push_pkt(0, 1, 'hB0);
        push_pkt(3, 1, 'hB3);
        drive_inputs();
        wait_out("t1_ptr_wait", 2, 50);
        check_eq("t1_ptr_first", out_q[0], 'hB3);
        check_eq("t1_ptr_second", out_q[1], 'hB0);

        // Contention: four 2-flit packets at once
        do_reset();
        for (int i = 0; i < NR; i++) push_pkt(i, 2, 'hC0 + 16 * i);
        drive_inputs();
        wait_out("t2_wait", 8, 100);
        for (int i = 0; i < NR; i++) begin
            check_eq("t2_head", out_q[2*i], DW'('hC0 + 16 * i));
            check_eq("t2_tail", out_q[2*i+1], DW'('hC1 + 16 * i));
            check_eq("t2_in_pkt", out_cyc[2*i+1] - out_cyc[2*i], 1);
            if (i < NR - 1) check_eq("t2_bubble", out_cyc[2*i+2] - out_cyc[2*i+1], 2);
        end
        clear_out();
        push_pkt(3, 1, 'hD3);
        push_pkt(0, 1, 'hD0);
        drive_inputs();
        wait_out("t2_ptr_wait", 2, 50);
        check_eq("t2_ptr_wrap", out_q[0], 'hD0);

        // Backpressure mid-packet
        do_reset();
        push_pkt(0, 6, 'h10);
        drive_inputs();
        wait_out("t3_wait_start", 2, 50);
        rdy_val = 0;
        drive_inputs();
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge noc_clk);
            if (c == 0) held = noc_flit;
            else check_eq("t3_hold_flit", noc_flit, held);
            check_eq("t3_hold_valid", noc_valid, 1);
            check_eq("t3_ready_zero", req_ready, 0);
        end
        tick(1);
        rdy_val = 1;
        drive_inputs();
        wait_out("t3_wait_end", 6, 50);
        check_eq("t3_count", out_q.size(), 6);
        for (int j = 0; j < 6; j++) check_eq("t3_flit", out_q[j], DW'('h10 + j));

        // Lock hold while the owner stalls
        do_reset();
        push_pkt(1, 4, 'h20);
        push_pkt(3, 2, 'h30);
        drive_inputs();
        wait_sent("t4_wait_two", 1, 2, 50);
        en[1] = 1'b0;
        drive_inputs();
        tick(3);
        check_eq("t4_req3_waiting", txq[3].size(), 2);
        en[1] = 1'b1;
        drive_inputs();
        wait_out("t4_wait_end", 6, 100);
        exp5 = '{'h20, 'h21, 'h22, 'h23, 'h30, 'h31};
        for (int j = 0; j < 6; j++) check_eq("t4_order", out_q[j], exp5[j]);

        // Single-flit packets alternate
        do_reset();
        busy_seen = 0;
        for (int r = 0; r < 3; r++) begin
            push_pkt(0, 1, 'h40 + r);
            push_pkt(1, 1, 'h50 + r);
        end
        drive_inputs();
        wait_out("t5_wait", 6, 100);
        for (int r = 0; r < 3; r++) begin
            check_eq("t5_req0", out_q[2*r], DW'('h40 + r));
            check_eq("t5_req1", out_q[2*r+1], DW'('h50 + r));
        end
        check_eq("t5_busy_never", busy_seen, 0);
        check_eq("t5_no_orphan", err_orphan, 0);

        // Orphan flit, then reset mid-packet
        do_reset();
        txq[2].push_back('{d: DW'('h66), h: 1'b0, t: 1'b0});
        drive_inputs();
        tick(1);
        @(negedge noc_clk);
        check_eq("t6_err_set", err_orphan, 1);
        check_eq("t6_not_ready", req_ready, 0);
        check_eq("t6_no_out", out_q.size(), 0);
        tick(1);
        txq[2].delete();
        drive_inputs();
        push_pkt(1, 4, 'h70);
        drive_inputs();
        wait_sent("t6_wait_two", 1, 2, 50);
        noc_rst = 1'b1;
        tick(1);
        check_eq("t6_rst_valid", noc_valid, 0);
        check_eq("t6_rst_flit", noc_flit, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_grant", grant_id, 0);
        check_eq("t6_rst_err", err_orphan, 0);
        check_eq("t6_rst_ready", req_ready, 0);
        clear_txq();
        noc_rst = 1'b0;
        drive_inputs();
        tick(2);

        // Randomized traffic
        do_reset();
        rnd_valid = 1;
        rnd_ready = 1;
        total = 0;
        for (int i = 0; i < NR; i++) begin
            for (int p = 0; p < 4; p++) begin
                len = $urandom_range(4, 1);
                push_pkt(i, len, (i << 8) | (p << 4));
                total += len;
            end
        end
        drive_inputs();
        wait_out("rnd_wait", total, 3000);
        check_eq("rnd_count", out_q.size(), total);
        check_eq("rnd_no_orphan", err_orphan, 0);
        rnd_valid = 0;
        rnd_ready = 0;
        rdy_val = 1;
        drive_inputs();
        tick(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
